// File: rtl/hack_alu_pkg.sv
// Shared width default, control-word encodings and control struct for the Hack ALU.
package hack_alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned CTRL_W        = 6;

  // Control word, MSB first: zx, nx, zy, ny, f, no
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  localparam logic [CTRL_W-1:0] OP_ZERO    = 6'b101010;
  localparam logic [CTRL_W-1:0] OP_ONE     = 6'b111111;
  localparam logic [CTRL_W-1:0] OP_NEG1    = 6'b111010;
  localparam logic [CTRL_W-1:0] OP_X       = 6'b001100;
  localparam logic [CTRL_W-1:0] OP_Y       = 6'b110000;
  localparam logic [CTRL_W-1:0] OP_NOTX    = 6'b001101;
  localparam logic [CTRL_W-1:0] OP_NEGX    = 6'b001111;
  localparam logic [CTRL_W-1:0] OP_XPLUSY  = 6'b000010;
  localparam logic [CTRL_W-1:0] OP_XMINUSY = 6'b010011;
  localparam logic [CTRL_W-1:0] OP_YMINUSX = 6'b000111;
  localparam logic [CTRL_W-1:0] OP_XANDY   = 6'b000000;
  localparam logic [CTRL_W-1:0] OP_XORY    = 6'b010101;

endpackage

// File: rtl/hack_alu_core.sv
// Combinational Hack ALU datapath: operand zero/negate, add-or-and, result negate, flags.
module hack_alu_core
  import hack_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  alu_ctrl_t        ctrl,
  output logic [WIDTH-1:0] o_c,
  output logic             zr_c,
  output logic             ng_c
);

  logic [WIDTH-1:0] x1, x2, y1, y2, r;

  // Zeroing happens before negation on both operands
  always_comb begin
    x1 = ctrl.zx ? '0 : x;
    x2 = ctrl.nx ? ~x1 : x1;
    y1 = ctrl.zy ? '0 : y;
    y2 = ctrl.ny ? ~y1 : y1;
    r  = ctrl.f ? WIDTH'(x2 + y2) : (x2 & y2);
    o_c  = ctrl.no ? ~r : r;
    zr_c = (o_c == '0);
    ng_c = o_c[WIDTH-1];
  end

endmodule

// File: rtl/hack_alu.sv
// Hack ALU with one-cycle registered result, flags and valid qualifier.
module hack_alu
  import hack_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             out_valid
);

  alu_ctrl_t        ctrl;
  logic [WIDTH-1:0] o_c;
  logic             zr_c;
  logic             ng_c;

  assign ctrl = '{zx: zx, nx: nx, zy: zy, ny: ny, f: f, no: no};

  hack_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .x    (x),
    .y    (y),
    .ctrl (ctrl),
    .o_c  (o_c),
    .zr_c (zr_c),
    .ng_c (ng_c)
  );

  // Reset values keep zr/ng consistent with out == 0; idle cycles hold the result
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      zr        <= 1'b1;
      ng        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= o_c;
        zr  <= zr_c;
        ng  <= ng_c;
      end
    end
  end

endmodule

// File: tb/tb_hack_alu.sv
// Self-checking bench for hack_alu: directed vector table, hand sequences, random vs model.
module tb_hack_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] x, y;
  logic        zx, nx, zy, ny, f, no;
  logic [15:0] out;
  logic        zr, ng, out_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  c;
    logic [15:0] e_out;
    logic        e_zr;
    logic        e_ng;
  } vec_t;

  vec_t vecs[15];

  hack_alu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .zx        (zx),
    .nx        (nx),
    .zy        (zy),
    .ny        (ny),
    .f         (f),
    .no        (no),
    .out       (out),
    .zr        (zr),
    .ng        (ng),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference: bitwise NOT of an n-bit value is (2^n - 1) - v; add wraps mod 2^n
  function automatic logic [15:0] model(input logic [15:0] xv, input logic [15:0] yv,
                                        input logic [5:0] c);
    int x1, x2, y1, y2, r, o;
    x1 = c[5] ? 0 : int'(xv);
    x2 = c[4] ? 65535 - x1 : x1;
    y1 = c[3] ? 0 : int'(yv);
    y2 = c[2] ? 65535 - y1 : y1;
    r  = c[1] ? (x2 + y2) % 65536 : (x2 & y2);
    o  = c[0] ? 65535 - r : r;
    return 16'(o);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] e_out, input logic e_zr,
                         input logic e_ng, input logic e_ov);
    chk({name, ".out"}, out, e_out);
    chk({name, ".zr"}, 16'(zr), 16'(e_zr));
    chk({name, ".ng"}, 16'(ng), 16'(e_ng));
    chk({name, ".out_valid"}, 16'(out_valid), 16'(e_ov));
  endtask

  // Drive inputs, clock once, land #1 after the edge for sampling
  task automatic step(input logic r, input logic v, input logic [15:0] xv,
                      input logic [15:0] yv, input logic [5:0] c);
    rst = r;
    in_valid = v;
    x = xv;
    y = yv;
    {zx, nx, zy, ny, f, no} = c;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] m_out;
  logic        m_zr, m_ng, m_ov;

  initial begin
    vecs[0]  = '{16'h3524, 16'h5E81, 6'b000000, 16'h1400, 1'b0, 1'b0};
    vecs[1]  = '{16'h3524, 16'h5E81, 6'b010101, 16'h7FA5, 1'b0, 1'b0};
    vecs[2]  = '{16'h3524, 16'h5E81, 6'b000010, 16'h93A5, 1'b0, 1'b1};
    vecs[3]  = '{16'h3524, 16'h5E81, 6'b010011, 16'hD6A3, 1'b0, 1'b1};
    vecs[4]  = '{16'h3524, 16'h5E81, 6'b000111, 16'h295D, 1'b0, 1'b0};
    vecs[5]  = '{16'h3524, 16'h5E81, 6'b001101, 16'hCADB, 1'b0, 1'b1};
    vecs[6]  = '{16'h3524, 16'h5E81, 6'b001111, 16'hCADC, 1'b0, 1'b1};
    vecs[7]  = '{16'h3524, 16'h5E81, 6'b110000, 16'h5E81, 1'b0, 1'b0};
    vecs[8]  = '{16'h3524, 16'h5E81, 6'b101010, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{16'h3524, 16'h5E81, 6'b111111, 16'h0001, 1'b0, 1'b0};
    vecs[10] = '{16'h3524, 16'h5E81, 6'b111010, 16'hFFFF, 1'b0, 1'b1};
    vecs[11] = '{16'h3524, 16'h5E81, 6'b001100, 16'h3524, 1'b0, 1'b0};
    vecs[12] = '{16'h1234, 16'h1234, 6'b010011, 16'h0000, 1'b1, 1'b0};
    vecs[13] = '{16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0};
    vecs[14] = '{16'h8000, 16'h0000, 6'b001100, 16'h8000, 1'b0, 1'b1};

    // Reset with in_valid high must still give reset values
    step(1'b1, 1'b1, 16'h3524, 16'h5E81, 6'b000010);
    step(1'b1, 1'b1, 16'h3524, 16'h5E81, 6'b000010);
    chk_all("reset", 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 16'h3524, 16'h5E81, 6'b000010);
    chk_all("reset_hold", 16'h0000, 1'b1, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      step(1'b0, 1'b1, vecs[i].x, vecs[i].y, vecs[i].c);
      chk_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_zr, vecs[i].e_ng, 1'b1);
    end

    // Back-to-back ops, then idle hold
    step(1'b0, 1'b1, 16'h3524, 16'h5E81, 6'b000010);
    chk_all("b2b0", 16'h93A5, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h3524, 16'h5E81, 6'b000000);
    chk_all("b2b1", 16'h1400, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h3524, 16'h5E81, 6'b001111);
    chk_all("b2b2", 16'hCADC, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 6'b101010);
    chk_all("hold0", 16'hCADC, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 16'h1111, 16'h2222, 6'b000010);
    chk_all("hold1", 16'hCADC, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h3524, 16'h5E81, 6'b111010);
    chk_all("mid_reset", 16'h0000, 1'b1, 1'b0, 1'b0);

    // Randomized run against the model, with occasional resets and idle cycles
    m_out = 16'h0000; m_zr = 1'b1; m_ng = 1'b0; m_ov = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic r, v;
      logic [15:0] xv, yv, o;
      logic [5:0] c;
      r  = ($urandom_range(0, 31) == 0);
      v  = ($urandom_range(0, 3) != 0);
      xv = 16'($urandom);
      yv = (i % 8 == 0) ? xv : 16'($urandom);
      c  = 6'($urandom);
      o  = model(xv, yv, c);
      step(r, v, xv, yv, c);
      if (r) begin
        m_out = 16'h0000; m_zr = 1'b1; m_ng = 1'b0; m_ov = 1'b0;
      end else begin
        m_ov = v;
        if (v) begin
          m_out = o;
          m_zr = (o == 16'h0000);
          m_ng = (o >= 16'h8000);
        end
      end
      chk_all($sformatf("rand%0d", i), m_out, m_zr, m_ng, m_ov);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
